// File: rtl/return_stack.sv
// Hardware return-address stack for call/return handling in the instruction controller.
// Pops present the old top one cycle later; a simultaneous push and pop replaces the top in place.
module return_stack #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clock,
    input  logic                    init_signal,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ADDR_WIDTH-1:0]   pushAddress,
    input  logic                    clearErrors,
    output logic [ADDR_WIDTH-1:0]   returnAddress,
    output logic                    returnValid,
    output logic [ADDR_WIDTH-1:0]   topAddress,
    output logic [$clog2(DEPTH):0]  depth,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_V = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_V   = (PW+1)'(1);

    logic [ADDR_WIDTH-1:0] entries [DEPTH];
    logic [PW-1:0]         top_idx;
    logic [PW-1:0]         wr_idx;
    logic                  wr_en;
    logic                  overflow_evt;
    logic                  underflow_evt;

    always_comb begin
        full          = (depth == DEPTH_V);
        empty         = (depth == '0);
        // depth==DEPTH truncates to 0, so the wrap yields DEPTH-1 as the top index
        top_idx       = depth[PW-1:0] - PW'(1);
        topAddress    = empty ? '0 : entries[top_idx];
        wr_idx        = (pop && !empty) ? top_idx : depth[PW-1:0];
        wr_en         = init_signal && push && (pop || !full);
        overflow_evt  = push && !pop && full;
        underflow_evt = pop && empty;
    end

    // Entry storage is intentionally left out of reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            entries[wr_idx] <= pushAddress;
        end
    end

    always_ff @(posedge clock) begin
        if (!init_signal) begin
            depth         <= '0;
            returnAddress <= '0;
            returnValid   <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            returnValid <= pop;
            if (pop) begin
                returnAddress <= topAddress;
            end

            if (push && !pop && !full) begin
                depth <= depth + ONE_V;
            end else if (pop && !push && !empty) begin
                depth <= depth - ONE_V;
            end else if (push && pop && empty) begin
                depth <= ONE_V;
            end

            // A new error event outranks a clear in the same cycle
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (clearErrors) begin
                overflow <= 1'b0;
            end

            if (underflow_evt) begin
                underflow <= 1'b1;
            end else if (clearErrors) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed scenarios plus randomized traffic,
// compared against a queue-based stack model with a decoupled return-value scoreboard.
module tb_return_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 12;

    logic          clock = 1'b0;
    logic          init_signal = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] pushAddress = '0;
    logic          clearErrors = 1'b0;
    logic [AW-1:0] returnAddress;
    logic          returnValid;
    logic [AW-1:0] topAddress;
    logic [$clog2(DEPTH):0] depth;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    return_stack #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .init_signal  (init_signal),
        .push         (push),
        .pop          (pop),
        .pushAddress  (pushAddress),
        .clearErrors  (clearErrors),
        .returnAddress(returnAddress),
        .returnValid  (returnValid),
        .topAddress   (topAddress),
        .depth        (depth),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: the stack is a plain queue, back = top.
    int unsigned model[$];
    int unsigned exp_q[$];
    int unsigned exp_ret = 0;
    bit          exp_ov  = 0;
    bit          exp_un  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare the post-edge state.
    task automatic step(input bit p, input bit q, input int unsigned a, input bit c, input bit rst_n);
        bit was_empty;
        bit was_full;
        int unsigned ret;
        push = p; pop = q; pushAddress = a[AW-1:0]; clearErrors = c; init_signal = rst_n;
        if (!rst_n) begin
            model.delete();
            exp_ret = 0; exp_ov = 0; exp_un = 0;
        end else begin
            was_empty = (model.size() == 0);
            was_full  = (model.size() == DEPTH);
            if (q) begin
                ret = was_empty ? 0 : model[$];
                exp_q.push_back(ret);
                exp_ret = ret;
                if (!was_empty) void'(model.pop_back());
            end
            if (p && !(was_full && !q)) model.push_back(a % (1 << AW));
            exp_ov = (p && !q && was_full) ? 1'b1 : (c ? 1'b0 : exp_ov);
            exp_un = (q && was_empty)      ? 1'b1 : (c ? 1'b0 : exp_un);
        end
        @(posedge clock);
        #2;
        check("depth",      32'(depth),         32'(model.size()));
        check("top",        32'(topAddress),    (model.size() == 0) ? 32'd0 : 32'(model[$]));
        check("full",       32'(full),          32'(model.size() == DEPTH));
        check("empty",      32'(empty),         32'(model.size() == 0));
        check("overflow",   32'(overflow),      32'(exp_ov));
        check("underflow",  32'(underflow),     32'(exp_un));
        check("ret_hold",   32'(returnAddress), 32'(exp_ret));
    endtask

    // Monitor: every returnValid pulse must match the oldest outstanding pop, exactly one cycle later.
    initial begin
        int unsigned e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ret_valid", 32'(returnValid), 32'd1);
                if (returnValid === 1'b1) check("ret_addr", 32'(returnAddress), 32'(e));
            end else begin
                check("no_valid", 32'(returnValid), 32'd0);
            end
        end
    end

    initial begin
        // Ordered push/pop
        step(0, 0, 0, 0, 0);
        step(1, 0, 'h010, 0, 1);
        step(1, 0, 'h020, 0, 1);
        step(1, 0, 'h030, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);

        // Overflow on the ninth push, then drain
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 'h100 + i * 'h11, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1);

        // Underflow, then clear; clear racing a new error keeps the flag
        step(0, 1, 0, 0, 1);
        check("underflow_set", 32'(underflow), 32'd1);
        step(0, 0, 0, 1, 1);
        check("underflow_clr", 32'(underflow), 32'd0);
        step(0, 1, 0, 1, 1);
        step(1, 1, 'h0F0, 0, 1);

        // Replace top with depth 2
        step(0, 0, 0, 0, 0);
        step(1, 0, 'h033, 0, 1);
        step(1, 0, 'h055, 0, 1);
        step(1, 1, 'h0AA, 0, 1);
        check("replace_top", 32'(topAddress), 32'h0AA);

        // Reset with a pop in the same cycle, then push
        for (int i = 0; i < 4; i++) step(1, 0, 'h200 + i, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 'h123, 0, 1);
        check("post_reset_top", 32'(topAddress), 32'h123);

        // Pop immediately followed by reset still yields its pulse
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Replace on a full stack
        for (int i = 0; i < 8; i++) step(1, 0, 'h300 + i, 0, 1);
        step(1, 1, 'h7FF, 0, 1);
        check("full_replace_top", 32'(topAddress), 32'h7FF);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 4095), $urandom_range(0, 99) < 5,
                 !($urandom_range(0, 99) < 2));
        end

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
